pos_sweep_ctrl: RTL and testbench
=================================

# pos_sweep_ctrl

Sequencer for the combinational sum/product-of-terms evaluators (PoS blocks, 3 or 4 inputs). On `start` it walks every input combination in truth-table order and drives it onto the evaluator inputs. It samples the evaluator output for each row into a truth-table register and checks each sample against the function programmed as a maxterm mask. It replaces the hand-written stimulus sweep with a self-checking hardware block that sits beside one evaluator instance.

## Interface
Parameters:
- `NVARS`, default 4: number of evaluator inputs; legal values 3 or 4. N = 2^NVARS rows.
- `SETTLE`, default 0: extra wait cycles per row before sampling; legal range 0..7.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  load `cfg_mask` into the mask register; honoured only in IDLE.
- `cfg_mask`  in  16  maxterm set; bit i = 1 means F(i) = 0. Bits at and above N are ignored.
- `start`  in  1  begin a sweep; honoured only in IDLE, level-sampled.
- `s`  in  1  evaluator output; combinational function of `vec`.
- `vec`  out  NVARS  evaluator inputs; MSB = x, then y, (w), LSB = z, so `vec` = row index.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `truth`  out  16  captured truth table; bit i = `s` sampled at row i. Bits ≥ N are always 0.
- `zeros`  out  5  number of rows where the sampled `s` = 0.
- `err_cnt`  out  5  number of rows where the sampled `s` ≠ ~mask[i].
- `err`  out  1  (`err_cnt` ≠ 0), valid with and after `done`.

## Operation
- State machine has three states: IDLE, SWEEP, DONE.
- **IDLE**
  - `cfg_we` = 1 loads the mask.
  - `start` = 1 clears `truth`, `zeros` and `err_cnt`, sets row = 0 and the wait counter to SETTLE, then moves to SWEEP.
  - If `cfg_we` and `start` are both high in the same cycle, the mask loads first and the sweep uses the new mask.
- **SWEEP**
  - `vec` = row.
  - While the wait counter is nonzero it decrements.
  - When the wait counter is 0, `s` is sampled:
    - `truth[row]` <= `s`.
    - `zeros` increments if `s` = 0.
    - `err_cnt` increments if `s` ≠ ~mask[row].
  - After sampling the last row (row = N−1), the state moves to DONE. Otherwise row increments and the wait counter reloads SETTLE.
- **DONE**: `done` = 1 for one cycle, `vec` returns to 0, then the state moves to IDLE.
- `cfg_we` and `start` outside IDLE are ignored and are not queued.
- Results (`truth`, `zeros`, `err_cnt`, `err`) hold their values until the next accepted `start` or `rst`.
- Counters saturate naturally: the maximum value is N = 16, which fits in 5 bits. No wrap is possible.
- Row counter: NVARS-bit comparison against N−1. It never wraps within a sweep.

## Timing
- Reset values:
  - State IDLE, `vec` = 0, `busy` = 0, `done` = 0.
  - `truth` = 0, `zeros` = 0, `err_cnt` = 0, `err` = 0.
  - Mask register = 0.
- `rst` mid-sweep aborts the sweep at the next edge. No `done` pulse is produced and all outputs take their reset values.
- If `start` is accepted at edge k:
  - `busy` = 1 and `vec` = 0 from cycle k+1.
  - Each row occupies 1+SETTLE cycles; `s` is sampled on the row's last cycle.
  - `busy` is high for exactly N·(1+SETTLE) cycles, followed by the `done` cycle (where `busy` = 0).
  - Final `truth`, `zeros` and `err_cnt` are visible in the `done` cycle.
- Back-to-back sweeps: `start` held high through DONE is accepted in the first IDLE cycle. The minimum period is N·(1+SETTLE)+2 cycles.
- All outputs are registered. `s` is the only combinational path, from `vec` through the evaluator back into the block.

## Test plan
- NVARS=3, SETTLE=0, evaluator F = ΠM(2,3,6,7), mask 0x00CC, start:
  - Required: `truth` = 0x33, `zeros` = 4, `err_cnt` = 0.
  - `busy` high for 8 cycles; `done` at start+9.
- NVARS=4, SETTLE=0, evaluator F = ΠM(0,1,2,4,6,8,12,14), mask 0x5157:
  - Required: `truth` = 0xAEA8, `zeros` = 8, `err_cnt` = 0.
  - `vec` steps 0..15 on consecutive cycles.
- NVARS=4, mask 0x5157, `s` tied to 0:
  - Required: `truth` = 0x0000, `zeros` = 16, `err_cnt` = 8, `err` = 1.
- NVARS=4, SETTLE=2, F = ΠM(0,2,4,6,9,10,13), mask 0x2655:
  - Required: each `vec` value held for 3 cycles; `busy` high for 48 cycles.
  - Required: `truth` = 0xD9AA, `err_cnt` = 0.
- Control hazards:
  - `cfg_we` with 0xFFFF at row 5 of a sweep: ignored, so `err_cnt` still reflects the old mask.
  - `start` pulsed mid-sweep: no restart.
  - `rst` at row 9: `busy` = 0, `truth` = 0, no `done` pulse.
  - A following start completes normally.
- `cfg_we` and `start` in the same IDLE cycle with mask 0x00CC (NVARS=3, F = ΠM(2,3,6,7)):
  - Required: the sweep uses the new mask, so `err_cnt` = 0.

Source files
------------

// File: rtl/pos_sweep_ctrl.sv
// Truth-table sweep sequencer for a small combinational evaluator.
// Walks every input row, captures the response and checks it against a maxterm mask.
module pos_sweep_ctrl #(
    parameter int NVARS  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [15:0]      cfg_mask,
    input  logic             start,
    input  logic             s,
    output logic [NVARS-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic [15:0]      truth,
    output logic [4:0]       zeros,
    output logic [4:0]       err_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [NVARS-1:0] LAST_ROW = '1;
    localparam logic [2:0]       SETTLE_V = 3'(SETTLE);

    state_t           state;
    state_t           state_next;
    logic [NVARS-1:0] row;
    logic [2:0]       wait_cnt;
    logic [15:0]      mask;
    logic             sample;
    logic             last;

    // A row is sampled on its final settle cycle; the last row ends the sweep.
    always_comb begin
        sample = (state == SWEEP) && (wait_cnt == 3'd0);
        last   = sample && (row == LAST_ROW);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SWEEP;
            SWEEP:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mask, row walker, settle counter and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask     <= 16'd0;
            row      <= '0;
            wait_cnt <= 3'd0;
            truth    <= 16'd0;
            zeros    <= 5'd0;
            err_cnt  <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_we) mask <= cfg_mask;
                    if (start) begin
                        truth    <= 16'd0;
                        zeros    <= 5'd0;
                        err_cnt  <= 5'd0;
                        row      <= '0;
                        wait_cnt <= SETTLE_V;
                    end
                end
                SWEEP: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        truth[row] <= s;
                        if (!s) zeros <= zeros + 5'd1;
                        // s must equal ~mask; equality with mask is a miss
                        if (s == mask[row]) err_cnt <= err_cnt + 5'd1;
                        wait_cnt <= SETTLE_V;
                        if (row == LAST_ROW) row <= '0;
                        else                 row <= row + 1'b1;
                    end
                end
                default: begin
                    row <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded straight from registers.
    always_comb begin
        vec  = row;
        busy = (state == SWEEP);
        done = (state == DONE);
        err  = (err_cnt != 5'd0);
    end

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// Directed bench for pos_sweep_ctrl: three configurations side by side,
// each with its own evaluator, sharing the control inputs.
module tb_pos_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [15:0] cfg_mask;
    logic        start;

    logic [2:0]  vec3;
    logic        s3, busy3, done3, err3;
    logic [15:0] truth3;
    logic [4:0]  zeros3, errc3;

    logic [3:0]  vec4;
    logic        s4, busy4, done4, err4;
    logic [15:0] truth4;
    logic [4:0]  zeros4, errc4;

    logic [3:0]  vec2;
    logic        s2, busy2, done2, err2;
    logic [15:0] truth2;
    logic [4:0]  zeros2, errc2;

    logic [15:0] tt_a = 16'hAEA8;
    logic [15:0] tt_b = 16'hD9AA;
    logic        tie0;

    int checks = 0;
    int failures = 0;
    int mon;

    logic        o_busy, o_done, o_err;
    logic [3:0]  o_vec;
    logic [15:0] o_truth;
    logic [4:0]  o_zeros, o_errc;

    always #5 clk = ~clk;

    // F = PiM(2,3,6,7): zero whenever y = 1
    assign s3 = ~vec3[1];
    assign s4 = tie0 ? 1'b0 : tt_a[vec4];
    assign s2 = tt_b[vec2];

    pos_sweep_ctrl #(.NVARS(3), .SETTLE(0)) u3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .start(start), .s(s3), .vec(vec3), .busy(busy3), .done(done3),
        .truth(truth3), .zeros(zeros3), .err_cnt(errc3), .err(err3)
    );

    pos_sweep_ctrl #(.NVARS(4), .SETTLE(0)) u4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .start(start), .s(s4), .vec(vec4), .busy(busy4), .done(done4),
        .truth(truth4), .zeros(zeros4), .err_cnt(errc4), .err(err4)
    );

    pos_sweep_ctrl #(.NVARS(4), .SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .start(start), .s(s2), .vec(vec2), .busy(busy2), .done(done2),
        .truth(truth2), .zeros(zeros2), .err_cnt(errc2), .err(err2)
    );

    always_comb begin
        o_busy  = busy4;
        o_done  = done4;
        o_err   = err4;
        o_vec   = vec4;
        o_truth = truth4;
        o_zeros = zeros4;
        o_errc  = errc4;
        if (mon == 0) begin
            o_busy  = busy3;
            o_done  = done3;
            o_err   = err3;
            o_vec   = {1'b0, vec3};
            o_truth = truth3;
            o_zeros = zeros3;
            o_errc  = errc3;
        end else if (mon == 2) begin
            o_busy  = busy2;
            o_done  = done2;
            o_err   = err2;
            o_vec   = vec2;
            o_truth = truth2;
            o_zeros = zeros2;
            o_errc  = errc2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [15:0] m);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_mask = m;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic settle_all();
        repeat (60) @(negedge clk);
    endtask

    // Pulse start (optionally with a mask load) and follow the monitored
    // instance until its done cycle; returns in the done cycle.
    task automatic sweep(input int m, input logic we, input logic [15:0] mk,
                         output int busy_n, output int done_at,
                         output int vec_bad);
        int per;
        per = (m == 2) ? 3 : 1;
        mon = m;
        @(negedge clk);
        cfg_we   = we;
        cfg_mask = mk;
        start    = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        start    = 1'b0;
        busy_n   = 0;
        done_at  = 0;
        vec_bad  = 0;
        for (int i = 1; i <= 80; i++) begin
            if (o_done) begin
                done_at = i;
                break;
            end
            if (o_busy) begin
                if (o_vec != 4'(busy_n / per)) vec_bad++;
                busy_n++;
            end
            @(negedge clk);
        end
    endtask

    int bn, da, vb, dn;

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_mask = 16'd0;
        start    = 1'b0;
        tie0     = 1'b0;
        mon      = 1;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_vec", 32'(vec4), 32'd0);
        chk("rst_truth", 32'(truth4), 32'd0);
        chk("rst_zeros", 32'(zeros4), 32'd0);
        chk("rst_errc", 32'(errc4), 32'd0);
        chk("rst_err", 32'(err4), 32'd0);
        rst = 1'b0;

        cfg(16'h00CC);
        sweep(0, 1'b0, 16'h0, bn, da, vb);
        chk("a_busy_n", 32'(bn), 32'd8);
        chk("a_done_at", 32'(da), 32'd9);
        chk("a_vec", 32'(vb), 32'd0);
        chk("a_truth", 32'(o_truth), 32'h33);
        chk("a_zeros", 32'(o_zeros), 32'd4);
        chk("a_errc", 32'(o_errc), 32'd0);
        @(negedge clk);
        chk("a_done_1cyc", 32'(done3), 32'd0);
        chk("a_truth_hold", 32'(truth3), 32'h33);
        settle_all();

        cfg(16'h5157);
        sweep(1, 1'b0, 16'h0, bn, da, vb);
        chk("b_busy_n", 32'(bn), 32'd16);
        chk("b_done_at", 32'(da), 32'd17);
        chk("b_vec", 32'(vb), 32'd0);
        chk("b_truth", 32'(o_truth), 32'hAEA8);
        chk("b_zeros", 32'(o_zeros), 32'd8);
        chk("b_errc", 32'(o_errc), 32'd0);
        chk("b_err", 32'(o_err), 32'd0);
        settle_all();

        tie0 = 1'b1;
        sweep(1, 1'b0, 16'h0, bn, da, vb);
        chk("c_truth", 32'(o_truth), 32'h0);
        chk("c_zeros", 32'(o_zeros), 32'd16);
        chk("c_errc", 32'(o_errc), 32'd8);
        chk("c_err", 32'(o_err), 32'd1);
        tie0 = 1'b0;
        settle_all();

        cfg(16'h2655);
        sweep(2, 1'b0, 16'h0, bn, da, vb);
        chk("d_busy_n", 32'(bn), 32'd48);
        chk("d_done_at", 32'(da), 32'd49);
        chk("d_vec", 32'(vb), 32'd0);
        chk("d_truth", 32'(o_truth), 32'hD9AA);
        chk("d_zeros", 32'(o_zeros), 32'd7);
        chk("d_errc", 32'(o_errc), 32'd0);
        settle_all();

        // mask write and restart attempts in the middle of a sweep
        cfg(16'h5157);
        mon = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        da = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 6) begin
                chk("h_row5", 32'(vec4), 32'd5);
                cfg_we   = 1'b1;
                cfg_mask = 16'hFFFF;
            end
            if (i == 7) begin
                cfg_we = 1'b0;
                start  = 1'b1;
            end
            if (i == 8) start = 1'b0;
            if (done4) begin
                da = i;
                break;
            end
            @(negedge clk);
        end
        chk("h_done_at", 32'(da), 32'd17);
        chk("h_errc", 32'(errc4), 32'd0);
        chk("h_truth", 32'(truth4), 32'hAEA8);
        settle_all();

        // reset in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("r_row9", 32'(vec4), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_busy", 32'(busy4), 32'd0);
        chk("r_truth", 32'(truth4), 32'h0);
        chk("r_vec", 32'(vec4), 32'd0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done4) dn++;
            @(negedge clk);
        end
        chk("r_no_done", 32'(dn), 32'd0);
        sweep(1, 1'b1, 16'h5157, bn, da, vb);
        chk("r_after_done_at", 32'(da), 32'd17);
        chk("r_after_truth", 32'(o_truth), 32'hAEA8);
        chk("r_after_errc", 32'(o_errc), 32'd0);
        settle_all();

        // mask load and start in the same idle cycle
        cfg(16'hFFFF);
        sweep(0, 1'b1, 16'h00CC, bn, da, vb);
        chk("s_done_at", 32'(da), 32'd9);
        chk("s_errc", 32'(o_errc), 32'd0);
        chk("s_truth", 32'(o_truth), 32'h33);
        settle_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
